// File: rtl/half_div_ctrl_if.sv
// Ratio-configuration channel of the fractional (N + 0.5) divider sequencer.
// The master offers an integer divisor plus a half-step flag over valid/ready;
// the slave reports a rejected (illegal) ratio with a one-cycle error pulse.
interface half_div_ctrl_if #(
  parameter int CNT_W = 4
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div_int;
  logic             cfg_half;
  logic             cfg_err;

  // Side that offers new ratios (register/config logic).
  modport master (
    output cfg_valid,
    output cfg_div_int,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  // Side that consumes ratios (the sequencer).
  modport slave (
    input  cfg_valid,
    input  cfg_div_int,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );

endinterface : half_div_ctrl_if

// File: rtl/half_div_ctrl.sv
// Tick sequencer for the (N + 0.5) clock-divider family.
// A frame is period A (div_int cycles) followed by period B (div_int + half
// cycles), each ending in a one-cycle tick, so the average tick period is
// div_int + 0.5*half. New ratios are held as pending and only take effect at
// a frame boundary (or immediately when idle), so the average never glitches.
module half_div_ctrl #(
  parameter int CNT_W    = 4,
  parameter int RST_DIV  = 3,
  parameter bit RST_HALF = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  half_div_ctrl_if.slave     cfg,
  output logic               tick,
  output logic               phase,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN_A = 2'd1,
    S_RUN_B = 2'd2
  } state_e;

  // Sequencer state
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             phase_q;

  // Active ratio
  logic [CNT_W-1:0] div_q, div_d;
  logic             half_q, half_d;

  // Pending ratio, waiting for the next frame boundary
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_half_q, pend_half_d;

  // Rejection pulse
  logic             err_q, err_d;

  // Decodes
  logic [CNT_W-1:0] half_add;
  logic [CNT_W-1:0] len_m1;
  logic             at_end;
  logic             frame_end;
  logic             cfg_xfer;
  logic             cfg_legal;
  logic             apply_cfg;

  // Last count of the current period: div-1 in A, div-1+half in B. With
  // div_int <= 2^CNT_W-1 the largest value is 2^CNT_W-1, so it fits in CNT_W.
  assign half_add  = (state_q == S_RUN_B && half_q) ? CNT_W'(1) : '0;
  assign len_m1    = div_q - CNT_W'(1) + half_add;

  // Tick is a pure decode of registered state and count (no input path).
  assign at_end    = (state_q != S_IDLE) && (cnt_q == len_m1);
  assign frame_end = (state_q == S_RUN_B) && at_end;

  // A handshake only happens while nothing is pending; a pending ratio is
  // applied as soon as the sequencer is idle or reaches the end of period B.
  assign cfg_xfer  = cfg.cfg_valid && !pend_vld_q;
  assign cfg_legal = cfg.cfg_div_int >= CNT_W'(2);
  assign apply_cfg = pend_vld_q && ((state_q == S_IDLE) || frame_end);

  assign tick          = at_end;
  assign phase         = phase_q;
  assign busy          = busy_q;
  assign cfg.cfg_ready = !pend_vld_q;
  assign cfg.cfg_err   = err_q;

  // Period/frame sequencing with registered phase and busy flags.
  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // a blocking = would let later statements see the already-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_RUN_A;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            phase_q <= 1'b0;
          end
        end
        S_RUN_A: begin
          if (at_end) begin
            state_q <= S_RUN_B;
            cnt_q   <= '0;
            phase_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN_B: begin
          if (at_end) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            if (en) begin
              state_q <= S_RUN_A;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  // Ratio bookkeeping: accept/reject offers, promote pending to active.
  // NOTE: every output of this block is given its hold value first, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    div_d       = div_q;
    half_d      = half_q;
    pend_vld_d  = pend_vld_q;
    pend_div_d  = pend_div_q;
    pend_half_d = pend_half_q;
    err_d       = 1'b0;

    if (apply_cfg) begin
      div_d      = pend_div_q;
      half_d     = pend_half_q;
      pend_vld_d = 1'b0;
    end

    // Cannot coincide with apply_cfg: a transfer needs nothing pending.
    if (cfg_xfer) begin
      if (cfg_legal) begin
        pend_vld_d  = 1'b1;
        pend_div_d  = cfg.cfg_div_int;
        pend_half_d = cfg.cfg_half;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control registers of the ratio path, reset to the power-up ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= CNT_W'(RST_DIV);
      half_q     <= RST_HALF;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      half_q     <= half_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  // Pending ratio payload.
  // NOTE: deliberately not reset; it is only ever read while pend_vld_q is
  // set, and pend_vld_q is cleared by reset.
  always_ff @(posedge clk) begin
    pend_div_q  <= pend_div_d;
    pend_half_q <= pend_half_d;
  end

  // Structural invariants of the sequencer.
  a_tick_only_busy : assert property (@(posedge clk) disable iff (rst)
    tick |-> busy);
  a_cnt_in_period  : assert property (@(posedge clk) disable iff (rst)
    busy |-> (cnt_q <= len_m1));

endmodule : half_div_ctrl

// File: tb/tb_half_div_ctrl.sv
// Self-checking bench for half_div_ctrl. Every cycle's observed
// {tick, busy, phase, cfg_ready, cfg_err} is logged; each scenario builds the
// expected trace from frame arithmetic (period A = d, period B = d + h) and
// compares the whole window.
module tb_half_div_ctrl;

  localparam int CNT_W = 4;
  localparam int HMAX  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic tick, phase, busy;

  half_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  half_div_ctrl #(
    .CNT_W   (CNT_W),
    .RST_DIV (3),
    .RST_HALF(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .cfg  (cfg_if.slave),
    .tick (tick),
    .phase(phase),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit order: [4] tick, [3] busy, [2] phase, [1] cfg_ready, [0] cfg_err
  logic [4:0] obs_h [HMAX];
  logic [4:0] exp_h [HMAX];

  always @(negedge clk)
    if (cyc < HMAX) obs_h[cyc] = {tick, busy, phase, cfg_if.cfg_ready, cfg_if.cfg_err};

  int checks = 0;
  int errors = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    goto(cyc + 1);
    rst = 1'b0;
  endtask

  // Offer a ratio for exactly one cycle, then scramble the data lines.
  task automatic send_cfg(input int d, input int h);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_div_int = CNT_W'(d);
    cfg_if.cfg_half    = h[0];
    goto(cyc + 1);
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_div_int = CNT_W'($urandom);
    cfg_if.cfg_half    = 1'($urandom);
  endtask

  // ------------------------------------------------------- reference model
  function automatic void idle_exp(input int a, input int b);
    for (int c = a; c <= b; c++) exp_h[c] = 5'b00010;
  endfunction

  // Frame whose first A cycle is s; returns the frame's last (boundary) cycle.
  function automatic int add_frame(input int s, input int d, input int h);
    int last = s + 2*d + h - 1;
    for (int c = s; c <= last; c++) begin
      exp_h[c][4] = (c == s + d - 1) || (c == last);
      exp_h[c][3] = 1'b1;
      exp_h[c][2] = (c >= s + d);
    end
    return last;
  endfunction

  function automatic void ready_low(input int a, input int b);
    for (int c = a; c <= b; c++) exp_h[c][1] = 1'b0;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    int t0, rc, e;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 60);
    goto(t0 + 2);
    en = 1'b1;
    void'(add_frame(t0 + 3, 3, 1));
    goto(t0 + 4);
    send_cfg(9, 0);
    ready_low(t0 + 5, t0 + 9);
    rc = t0 + 6;
    goto(rc);
    rst = 1'b1;
    en  = 1'b0;
    goto(rc + 1);
    rst = 1'b0;
    idle_exp(rc + 1, t0 + 60);
    goto(rc + 3);
    en = 1'b1;
    e = add_frame(rc + 4, 3, 1);
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL reset cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  task automatic test_defaults();
    int t0, s, e;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 60);
    en = 1'b1;
    s = t0 + 1;
    for (int f = 0; f < 4; f++) begin
      e = add_frame(s, 3, 1);
      s = e + 1;
    end
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL defaults cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  // Ratio set while idle, en raised the cycle it is applied.
  task automatic test_random_ratio();
    int t0, c0, d, h, e;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 600);
    c0 = t0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(2, 15);
      h = $urandom_range(0, 1);
      goto(c0);
      send_cfg(d, h);
      ready_low(c0 + 1, c0 + 1);
      en = 1'b1;
      e = add_frame(c0 + 2, d, h);
      e = add_frame(e + 1, d, h);
      goto(e);
      en = 1'b0;
      c0 = e + 2;
    end
    goto(c0 + 1);
    for (int c = t0; c <= c0; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL random_ratio cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  // Ratio changes offered mid-frame while running; applied at boundaries.
  task automatic test_cfg_midframe();
    int t0, s, e, cd, ch, d, h, tx;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 400);
    en = 1'b1;
    cd = 3;
    ch = 1;
    s  = add_frame(t0 + 1, cd, ch) + 1;
    for (int i = 0; i < 4; i++) begin
      d  = (i == 0) ? 5 : int'($urandom_range(2, 15));
      h  = (i == 0) ? 0 : int'($urandom_range(0, 1));
      tx = s + ((i == 0) ? 1 : int'($urandom_range(0, 2*cd + ch - 2)));
      e  = add_frame(s, cd, ch);
      ready_low(tx + 1, e);
      goto(tx);
      send_cfg(d, h);
      s  = e + 1;
      cd = d;
      ch = h;
    end
    e = add_frame(s, cd, ch);
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL cfg_midframe cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  task automatic test_illegal();
    int t0, s, e, tx;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 60);
    en = 1'b1;
    send_cfg(0, $urandom_range(0, 1));
    exp_h[t0 + 1][0] = 1'b1;
    s = t0 + 1;
    for (int f = 0; f < 3; f++) begin
      e  = add_frame(s, 3, 1);
      tx = s + $urandom_range(0, 5);
      goto(tx);
      send_cfg(f % 2, $urandom_range(0, 1));
      exp_h[tx + 1][0] = 1'b1;
      s = e + 1;
    end
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL illegal cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  // Offer on the exact boundary tick; then the widest ratio 15.5.
  task automatic test_boundary_xfer();
    int t0, e1, e2, e3, e4, tx;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 120);
    en = 1'b1;
    e1 = add_frame(t0 + 1, 3, 1);
    goto(e1);
    send_cfg(7, 1);
    e2 = add_frame(e1 + 1, 3, 1);
    ready_low(e1 + 1, e2);
    e3 = add_frame(e2 + 1, 7, 1);
    tx = e2 + 1 + $urandom_range(0, 13);
    goto(tx);
    send_cfg(15, 1);
    ready_low(tx + 1, e3);
    e4 = add_frame(e3 + 1, 15, 1);
    goto(e4);
    en = 1'b0;
    goto(e4 + 3);
    for (int c = t0; c <= e4 + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL boundary_xfer cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  // en drop mid-frame finishes the frame; a short drop inside a frame is invisible.
  task automatic test_en_drop();
    int t0, s, e, k, d1, d2;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 100);
    en = 1'b1;
    s = add_frame(t0 + 1, 3, 1) + 1;
    e = add_frame(s, 3, 1);
    goto(s + 1);
    en = 1'b0;
    k = $urandom_range(1, 4);
    goto(e + 1 + k);
    en = 1'b1;
    s  = cyc + 1;
    e  = add_frame(s, 3, 1);
    d1 = $urandom_range(s, e - 1);
    d2 = $urandom_range(d1 + 1, e);
    goto(d1);
    en = 1'b0;
    goto(d2);
    en = 1'b1;
    e = add_frame(e + 1, 3, 1);
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL en_drop cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  // Reset mid period B with a ratio pending: back to 3.5, pending discarded.
  task automatic test_mid_reset();
    int t0, e1, s2, e2, tx2, rc, e;
    do_reset();
    t0 = cyc;
    idle_exp(t0, t0 + 120);
    en = 1'b1;
    e1 = add_frame(t0 + 1, 3, 1);
    goto(t0 + 2);
    send_cfg(6, 0);
    ready_low(t0 + 3, e1);
    s2  = e1 + 1;
    e2  = add_frame(s2, 6, 0);
    tx2 = s2 + $urandom_range(0, 4);
    goto(tx2);
    send_cfg($urandom_range(2, 15), $urandom_range(0, 1));
    ready_low(tx2 + 1, e2);
    rc = s2 + 6 + $urandom_range(1, 4);
    goto(rc);
    rst = 1'b1;
    goto(rc + 1);
    rst = 1'b0;
    idle_exp(rc + 1, t0 + 120);
    e = add_frame(rc + 2, 3, 1);
    e = add_frame(e + 1, 3, 1);
    goto(e);
    en = 1'b0;
    goto(e + 3);
    for (int c = t0; c <= e + 2; c++) begin
      checks++;
      if (obs_h[c] !== exp_h[c]) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d tick,busy,phase,ready,err got %b want %b", c, obs_h[c], exp_h[c]);
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_div_int = '0;
    cfg_if.cfg_half    = 1'b0;
    test_reset();
    test_defaults();
    test_random_ratio();
    test_cfg_midframe();
    test_illegal();
    test_en_drop();
    test_boundary_xfer();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_half_div_ctrl

// File: doc/half_div_ctrl.md
Name: half_div_ctrl

Overview:
Single-clock sequencer for the fractional (N + 0.5) clock-divider family. It produces a one-cycle tick train whose average period is div_int + 0.5*half by alternating periods of N and N+half cycles. The block sits between the register/config interface and divider-gated logic. It accepts ratio changes through a valid/ready handshake and applies them only on frame boundaries, so the average ratio never glitches.

Parameters:
CNT_W, 4, width of divisor and period counter; max div_int = 2^CNT_W - 1
RST_DIV, 3, integer part of the active divisor after reset
RST_HALF, 1, half-step flag after reset (reset ratio 3.5)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_ready  output  1  block can accept a ratio
cfg_div_int  input  CNT_W  integer divisor, legal range 2..2^CNT_W-1
cfg_half  input  1  1 = add half cycle per period on average
tick  output  1  one-cycle pulse at the end of each period
phase  output  1  0 = period A of frame, 1 = period B
busy  output  1  1 while in RUN_A/RUN_B
cfg_err  output  1  one-cycle pulse when an illegal cfg is rejected

Behaviour:
- Reset (rst=1 at an edge): state IDLE; cnt=0; active div=RST_DIV, half=RST_HALF; pending cleared; tick=0, phase=0, busy=0, cfg_ready=1, cfg_err=0. Reset mid-frame aborts immediately and discards any pending config.
- States: IDLE, RUN_A, RUN_B. Period length: A = div_int; B = div_int + half. Frame = A then B = 2*div_int + half cycles, two ticks.
- IDLE: if en=1 at cycle t, enter RUN_A at t+1 with cnt=0. First tick at cycle t+div_int.
- In RUN_x, cnt increments each cycle. tick=1 exactly when cnt == len-1, decoded from registered state and cnt (Moore, no input path).
- At the tick cycle in RUN_A: go to RUN_B, cnt=0.
- At the tick cycle in RUN_B (frame boundary):
  - apply pending config if any;
  - if en=1, go to RUN_A with cnt=0; otherwise go to IDLE.
- phase = 1 in RUN_B, else 0. busy = 1 in RUN_A/RUN_B.
- en deasserted mid-frame: the current frame completes with both ticks, then IDLE. If en is reasserted before the boundary, the tick train is uninterrupted.
- Config handshake: transfer occurs when cfg_valid & cfg_ready.
  - If cfg_div_int < 2: reject. cfg_err=1 on the next cycle for one cycle; active and pending config unchanged; cfg_ready stays 1.
  - If legal: store as pending; cfg_ready=0 from the next cycle until applied.
- Applying pending config:
  - in IDLE: applied the cycle after the transfer; cfg_ready returns to 1 the cycle after that;
  - while running: applied at the next frame boundary; cfg_ready returns to 1 the following cycle.
- Transfer in the same cycle as a boundary: not used at that boundary; applied at the next boundary.
- en rising in the same cycle a pending config is applied in IDLE: the RUN_A period uses the new config.
- Width: max period = 2^CNT_W cycles (B with half=1, div_int=15); cnt reaches at most 2^CNT_W - 1, no overflow. cfg inputs are sampled only on transfer.

Test Plan:
1. Defaults: rst, then hold en=1 from cycle t -> first tick at t+3, then tick spacings 4,3,4,3…; phase toggles after each tick; busy=1.
2. Running at 3.5, send cfg_div_int=5, cfg_half=0 mid period A -> cfg_ready=0 until the current frame ends, then tick spacings 5,5,5; cfg_ready=1 one cycle after the boundary.
3. Send cfg_div_int=1 (and 0) -> cfg_err single-cycle pulse each, tick spacing stays 3/4, cfg_ready stays 1.
4. Drop en at cnt=1 of period A (3.5) -> exactly two more ticks (A end, B end), then busy=0, tick=0; re-raise en -> restarts with period A.
5. Transfer cfg 7/half=1 on the exact RUN_B tick cycle -> next frame keeps 3/4; the frame after uses 7/8. Also cfg 15/half=1 -> period B = 16 cycles, no wrap.
6. Assert rst for one cycle mid-period B after setting 6/0 -> next cycle tick=0, busy=0, cfg_ready=1; with en=1, spacings return to 3,4.
